reg_file_16: RTL and testbench
==============================

REG_FILE_16 -- requirements
Module: reg_file_16

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter NREG, default 8, SHALL set the number of registers (power of two).
REQ-003 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 we  input  1  SHALL be the write enable, sampled at the rising edge of clk.
REQ-007 waddr  input  log2(NREG)  SHALL give the write register index.
REQ-008 wdata  input  WIDTH  SHALL give the write data.
REQ-009 raddr_a  input  log2(NREG)  SHALL give the read port A index.
REQ-010 raddr_b  input  log2(NREG)  SHALL give the read port B index.
REQ-011 rdata_a  output  WIDTH  SHALL give the read port A data.
REQ-012 rdata_b  output  WIDTH  SHALL give the read port B data.
REQ-013 wr_zero_err  output  1  SHALL be a sticky flag that an attempt was made to write r0.
REQ-014 wr_count  output  8  SHALL count accepted writes.

Function
REQ-015 The write path SHALL decode waddr one-hot: exactly one register enable is active when we=1, and none when we=0.
REQ-016 When we=1 and waddr!=0, the addressed register SHALL take wdata at the rising clk edge; all other registers SHALL hold.
REQ-017 r0 SHALL be hardwired to 0; when we=1 and waddr=0, no state SHALL change except wr_zero_err.
REQ-018 Read ports SHALL be combinational (zero-cycle latency) and independent; both ports may address the same register.
REQ-019 Reading r0 SHALL always return 0, including under bypass.
REQ-020 When BYPASS=1, we=1, waddr!=0 and raddr_x==waddr, rdata_x SHALL equal wdata in the same cycle.
REQ-021 When BYPASS=0, rdata_x SHALL show the pre-edge register value until the edge, then the new value.
REQ-022 wr_zero_err SHALL set on the edge where we=1 and waddr=0, and SHALL stay set until reset.
REQ-023 wr_count SHALL increment by 1 on each edge with we=1 and waddr!=0, and SHALL wrap from 255 to 0.
REQ-024 Out-of-range indices cannot occur (NREG is a power of two); X/Z on a read index SHALL NOT corrupt stored state.

Reset
REQ-025 Asserting rst_n=0 SHALL clear all registers, wr_zero_err and wr_count immediately, independent of clk.
REQ-026 While rst_n=0, writes SHALL be ignored and rdata_a and rdata_b SHALL read 0, bypass included.
REQ-027 A write whose edge coincides with reset assertion SHALL be lost; the first write after release SHALL take effect on the first rising edge with rst_n=1.

Structure
REQ-028 datapath_pkg SHALL hold WIDTH, NREG, the address width constant and the data word typedef, shared with MUX_16bit and the ALU.
REQ-029 One sub-module, reg16 (WIDTH-bit register with load enable and asynchronous active-low clear), SHALL be instantiated NREG-1 times.
REQ-030 The decoder and read muxes SHALL be inline logic, with no further sub-modules.

Verification
REQ-031 Reset then read all indices on both ports -> every rdata is 0x0000, wr_count=0, wr_zero_err=0.
REQ-032 Write r3=0x0010 and r5=0x0017, then raddr_a=3, raddr_b=5 -> rdata_a=0x0010, rdata_b=0x0017; wr_count=2.
REQ-033 Write r0=0xFFFF -> rdata of r0 stays 0x0000, wr_zero_err=1 and holds, wr_count unchanged.
REQ-034 BYPASS=1, we=1, waddr=4, wdata=0xBEEF, raddr_a=4 before the edge -> rdata_a=0xBEEF in the same cycle; with BYPASS=0 -> old value until the edge.
REQ-035 Perform 256 writes -> wr_count wraps to 0; assert rst_n mid-cycle after writing r7=0x1234 -> r7 reads 0 immediately.
REQ-036 A random write/read sequence checked against a reference model -> no mismatch over 10,000 cycles.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants and word type for the register file, MUX_16bit and ALU.
package datapath_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/reg16.sv
// Parameterised data register with load enable and asynchronous active-low clear.
module reg16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_16.sv
// Two-read, one-write register file with r0 hardwired to zero and optional write forwarding.
module reg_file_16
  import datapath_pkg::*;
#(
  parameter  int unsigned WIDTH  = WORD_W,
  parameter  int unsigned NREG   = NUM_REGS,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             wr_zero_err,
  output logic [7:0]       wr_count
);

  logic [NREG-1:0]  wr_sel;
  logic             wr_real;
  logic [WIDTH-1:0] regs [NREG];

  // One-hot write decode; bit 0 only flags the illegal r0 write.
  always_comb begin
    wr_sel = '0;
    if (we) begin
      wr_sel = NREG'(1) << waddr;
    end
  end

  assign wr_real = |wr_sel[NREG-1:1];

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    reg16 #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_sel[i]),
      .d     (wdata),
      .q     (regs[i])
    );
  end

  // Write bookkeeping: sticky r0-write flag and wrapping accepted-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_zero_err <= 1'b0;
      wr_count    <= 8'd0;
    end else begin
      if (wr_sel[0]) begin
        wr_zero_err <= 1'b1;
      end
      if (wr_real) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

  // Forwarding never applies to r0 since wr_real excludes it; reset forces zero.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if ((BYPASS != 0) && wr_real && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
    if ((BYPASS != 0) && wr_real && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
    if (!rst_n) begin
      rdata_a = '0;
      rdata_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_16.sv
// Scoreboard bench for reg_file_16, covering forwarding and non-forwarding builds.
module tb_reg_file_16;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr, raddr_a, raddr_b;
  word_t       wdata;
  word_t       rdata_a, rdata_b, rdata_a_nb, rdata_b_nb;
  logic        zerr, zerr_nb;
  logic [7:0]  cnt, cnt_nb;

  always #5 clk = ~clk;

  reg_file_16 #(.WIDTH(16), .NREG(8), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .wr_zero_err(zerr), .wr_count(cnt)
  );

  reg_file_16 #(.WIDTH(16), .NREG(8), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a_nb), .rdata_b(rdata_b_nb),
    .wr_zero_err(zerr_nb), .wr_count(cnt_nb)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  event        chk_ev;

  // Reference model
  logic [15:0] m [8];
  logic [7:0]  mcnt;
  logic        mzerr;

  function automatic logic [15:0] actual(int sel);
    case (sel)
      0: return rdata_a;
      1: return rdata_b;
      2: return 16'(cnt);
      3: return 16'(zerr);
      4: return rdata_a_nb;
      5: return rdata_b_nb;
      6: return 16'(cnt_nb);
      default: return 16'(zerr_nb);
    endcase
  endfunction

  // Monitor: drains the scoreboard whenever the bench presents a sample point.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic [15:0] a;
        e = q.pop_front();
        a = actual(e.sel);
        checks++;
        if (a !== e.val) begin
          errors++;
          $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", e.name, a, e.val, $time);
        end
      end
    end
  end

  // Immediate comparison, used outside the scoreboard flow.
  task automatic check_eq(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void push(string name, int sel, logic [15:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endfunction

  function automatic logic [15:0] exp_rd(logic [2:0] ra, bit byp);
    if (!rst_n || ra == 3'd0) return 16'h0000;
    if (byp && we && waddr != 3'd0 && waddr == ra) return wdata;
    return m[ra];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    mcnt  = 8'd0;
    mzerr = 1'b0;
  endfunction

  function automatic void push_all(string tag);
    push({tag, "_a"},     0, exp_rd(raddr_a, 1'b1));
    push({tag, "_b"},     1, exp_rd(raddr_b, 1'b1));
    push({tag, "_a_nb"},  4, exp_rd(raddr_a, 1'b0));
    push({tag, "_b_nb"},  5, exp_rd(raddr_b, 1'b0));
    push({tag, "_cnt"},   2, 16'(mcnt));
    push({tag, "_zerr"},  3, 16'(mzerr));
    push({tag, "_cnt_nb"}, 6, 16'(mcnt));
    push({tag, "_zerr_nb"}, 7, 16'(mzerr));
  endfunction

  // One clock of stimulus: drive after the edge, queue expectations, then advance the model.
  task automatic cycle(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb, input string tag);
    @(posedge clk);
    #1;
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    push_all(tag);
    if (rst_n && w) begin
      if (wa != 3'd0) begin
        m[wa] = wd;
        mcnt  = mcnt + 8'd1;
      end else begin
        mzerr = 1'b1;
      end
    end
  endtask

  initial begin
    logic [7:0] c0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    model_reset();
    #1;
    check_eq("rst_state_cnt", 16'(cnt), 16'h0000);
    check_eq("rst_state_zerr", 16'(zerr), 16'h0000);
    check_eq("rst_state_cnt_nb", 16'(cnt_nb), 16'h0000);
    check_eq("rst_state_zerr_nb", 16'(zerr_nb), 16'h0000);

    // In reset: every index reads zero, writes ignored, bypass suppressed.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'(i), 16'hFFFF, 3'(i), 3'(7 - i), "rst_read");
    end
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;

    cycle(1'b1, 3'd3, 16'h0010, 3'd0, 3'd0, "wr_r3");
    cycle(1'b1, 3'd5, 16'h0017, 3'd3, 3'd5, "wr_r5");
    cycle(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, "rd_35");
    cycle(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "wr_r0");
    cycle(1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, "r0_after");
    cycle(1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, "zerr_hold");
    cycle(1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4, "bypass");
    cycle(1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, "post_edge");

    // 256 accepted writes must bring the counter back to its start value.
    c0 = mcnt;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 3'(1 + (i % 7)), 16'(i * 3), 3'(i % 8), 3'((i + 1) % 8), "wrap_loop");
    end
    cycle(1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, "wrap");
    push("wrap_exact", 2, 16'(c0));

    // Mid-cycle reset after writing r7.
    cycle(1'b1, 3'd7, 16'h1234, 3'd7, 3'd7, "wr_r7");
    cycle(1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, "rd_r7");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    we = 1'b1; waddr = 3'd4; wdata = 16'hAAAA; raddr_a = 3'd7; raddr_b = 3'd4;
    #1;
    check_eq("async_rst_r7_now", rdata_a, 16'h0000);
    check_eq("async_rst_r7_now_nb", rdata_a_nb, 16'h0000);
    model_reset();
    push_all("async_rst");
    -> chk_ev;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    cycle(1'b1, 3'd7, 16'h5555, 3'd7, 3'd7, "first_wr");
    cycle(1'b0, 3'd0, 16'h0000, 3'd7, 3'd4, "first_wr_rd");

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
            3'($urandom_range(7)), 3'($urandom_range(7)), "rand");
    end

    @(negedge clk);
    #1;
    -> chk_ev;

    // Bounded wait for the scoreboard to drain; leftovers mean the wait expired.
    fork
      wait (q.size() == 0);
      #100;
    join_any
    disable fork;
    check_eq("scoreboard_drain_timeout", 16'(q.size()), 16'h0000);

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
